// File: rtl/arcade_input_ctrl.sv
// Player input conditioning for the arcade core: registered controls, debounced
// coin/pause buttons, shaped coin pulses, pause request and idle screen dimming.
module arcade_input_ctrl #(
  parameter logic [15:0] DEBOUNCE     = 16'd1800,
  parameter logic [23:0] COIN_PULSE   = 24'd1800000,
  parameter logic [23:0] COIN_HOLDOFF = 24'd900000,
  parameter logic [31:0] DIM_DELAY    = 32'h0ABA9500
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [15:0] joystick_0,
  input  logic [15:0] joystick_1,
  input  logic        osd_status,
  input  logic        osd_pause_en,
  input  logic        hs_access,
  output logic        m_up,
  output logic        m_down,
  output logic        m_left,
  output logic        m_right,
  output logic        m_fire,
  output logic        m_start1,
  output logic        m_start2,
  output logic        m_coin1,
  output logic        m_coin2,
  output logic        pause,
  output logic        dim_video
);

  typedef enum logic [1:0] {IDLE, PULSE, HOLDOFF} coin_state_t;

  logic [2:0]  db_raw;
  logic [2:0]  db_stable;
  logic [2:0]  db_stable_d;
  logic [2:0]  db_rise;
  logic [15:0] db_cnt [3];

  coin_state_t coin_state [2];
  coin_state_t coin_next  [2];
  logic [23:0] coin_cnt      [2];
  logic [23:0] coin_cnt_next [2];

  logic        pause_toggle;
  logic [31:0] dim_timer;
  logic        unused_bits;

  assign unused_bits = ^{joystick_0[15:9], joystick_1[15:9]};

  // Debouncer inputs: bit 0 coin1, bit 1 coin2, bit 2 either player's pause
  assign db_raw  = {joystick_0[8] | joystick_1[8], joystick_1[7], joystick_0[7]};
  assign db_rise = db_stable & ~db_stable_d;

  // Stage p1: direction, fire and start, one register, no filtering
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      m_up     <= 1'b0;
      m_down   <= 1'b0;
      m_left   <= 1'b0;
      m_right  <= 1'b0;
      m_fire   <= 1'b0;
      m_start1 <= 1'b0;
      m_start2 <= 1'b0;
    end else begin
      m_right  <= joystick_0[0] | joystick_1[0];
      m_left   <= joystick_0[1] | joystick_1[1];
      m_down   <= joystick_0[2] | joystick_1[2];
      m_up     <= joystick_0[3] | joystick_1[3];
      m_fire   <= joystick_0[4] | joystick_1[4];
      m_start1 <= joystick_0[5] | joystick_1[6];
      m_start2 <= joystick_1[5] | joystick_0[6];
    end
  end

  always_ff @(posedge clk_sys) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        db_cnt[i]      <= '0;
        db_stable[i]   <= 1'b0;
        db_stable_d[i] <= 1'b0;
      end else begin
        db_stable_d[i] <= db_stable[i];
        if (db_raw[i] == db_stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DEBOUNCE - 16'd1) begin
          db_stable[i] <= db_raw[i];
          db_cnt[i]    <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 16'd1;
        end
      end
    end
  end

  // Coin shaping: edges arriving outside IDLE are dropped, not queued
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      coin_next[i]     = coin_state[i];
      coin_cnt_next[i] = coin_cnt[i];
      case (coin_state[i])
        IDLE: begin
          if (db_rise[i]) begin
            coin_next[i]     = PULSE;
            coin_cnt_next[i] = '0;
          end
        end
        PULSE: begin
          if (coin_cnt[i] == COIN_PULSE - 24'd1) begin
            coin_next[i]     = HOLDOFF;
            coin_cnt_next[i] = '0;
          end else begin
            coin_cnt_next[i] = coin_cnt[i] + 24'd1;
          end
        end
        HOLDOFF: begin
          if (coin_cnt[i] == COIN_HOLDOFF - 24'd1) begin
            coin_next[i]     = IDLE;
            coin_cnt_next[i] = '0;
          end else begin
            coin_cnt_next[i] = coin_cnt[i] + 24'd1;
          end
        end
        default: begin
          coin_next[i]     = IDLE;
          coin_cnt_next[i] = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        coin_state[i] <= IDLE;
        coin_cnt[i]   <= '0;
      end else begin
        coin_state[i] <= coin_next[i];
        coin_cnt[i]   <= coin_cnt_next[i];
      end
    end
  end

  assign m_coin1 = (coin_state[0] == PULSE);
  assign m_coin2 = (coin_state[1] == PULSE);

  // Only the user pause toggle feeds the dim timer; OSD and hiscore halts never dim
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      pause_toggle <= 1'b0;
      dim_timer    <= '0;
      dim_video    <= 1'b0;
    end else begin
      if (db_rise[2]) pause_toggle <= ~pause_toggle;
      if (!pause_toggle)               dim_timer <= '0;
      else if (dim_timer < DIM_DELAY)  dim_timer <= dim_timer + 32'd1;
      dim_video <= pause_toggle & (dim_timer >= DIM_DELAY);
    end
  end

  assign pause = hs_access | pause_toggle | (osd_status & osd_pause_en);

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Directed bench for arcade_input_ctrl with short debounce/coin/dim timings.
module tb_arcade_input_ctrl;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [15:0] joystick_0;
  logic [15:0] joystick_1;
  logic        osd_status;
  logic        osd_pause_en;
  logic        hs_access;
  logic        m_up, m_down, m_left, m_right, m_fire;
  logic        m_start1, m_start2, m_coin1, m_coin2;
  logic        pause, dim_video;

  int total = 0;
  int bad   = 0;

  logic [9:0] outs;
  assign outs = {m_up, m_down, m_left, m_right, m_fire,
                 m_start1, m_start2, m_coin1, m_coin2, dim_video};

  arcade_input_ctrl #(
    .DEBOUNCE    (16'd4),
    .COIN_PULSE  (24'd8),
    .COIN_HOLDOFF(24'd16),
    .DIM_DELAY   (32'd100)
  ) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .joystick_0  (joystick_0),
    .joystick_1  (joystick_1),
    .osd_status  (osd_status),
    .osd_pause_en(osd_pause_en),
    .hs_access   (hs_access),
    .m_up        (m_up),
    .m_down      (m_down),
    .m_left      (m_left),
    .m_right     (m_right),
    .m_fire      (m_fire),
    .m_start1    (m_start1),
    .m_start2    (m_start2),
    .m_coin1     (m_coin1),
    .m_coin2     (m_coin2),
    .pause       (pause),
    .dim_video   (dim_video)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; joystick_0 = 16'hFFFF; joystick_1 = 16'hFFFF;
    osd_status = 1'b0; osd_pause_en = 1'b0; hs_access = 1'b0;
    repeat (3) tick();
    total++; if (outs !== 10'b0) begin bad++; $display("FAIL reset_outs got=%b exp=%b", outs, 10'b0); end
    total++; if (pause !== 1'b0) begin bad++; $display("FAIL reset_pause got=%b exp=0", pause); end
    hs_access = 1'b1; #1;
    total++; if (pause !== 1'b1) begin bad++; $display("FAIL reset_pause_hs got=%b exp=1", pause); end
    hs_access = 1'b0; osd_status = 1'b1; osd_pause_en = 1'b1; #1;
    total++; if (pause !== 1'b1) begin bad++; $display("FAIL reset_pause_osd got=%b exp=1", pause); end
    osd_pause_en = 1'b0; #1;
    total++; if (pause !== 1'b0) begin bad++; $display("FAIL reset_pause_osd_dis got=%b exp=0", pause); end
    osd_status = 1'b0;
    joystick_0 = 16'h0000; joystick_1 = 16'h0000;
    tick();
    reset = 1'b0;
    repeat (2) tick();
    total++; if (outs !== 10'b0) begin bad++; $display("FAIL reset_release got=%b exp=%b", outs, 10'b0); end
  endtask

  task automatic test_directions();
    joystick_0 = 16'h0009; #1;
    total++; if (outs !== 10'b0) begin bad++; $display("FAIL dir_latency got=%b exp=%b", outs, 10'b0); end
    tick();
    total++; if (outs !== 10'b1001000000) begin bad++; $display("FAIL dir_up_right got=%b exp=%b", outs, 10'b1001000000); end
    joystick_0 = 16'h0000; joystick_1 = 16'h0002; tick();
    total++; if (outs !== 10'b0010000000) begin bad++; $display("FAIL dir_left got=%b exp=%b", outs, 10'b0010000000); end
    joystick_1 = 16'h0040; tick();
    total++; if (outs !== 10'b0000010000) begin bad++; $display("FAIL start_swap1 got=%b exp=%b", outs, 10'b0000010000); end
    joystick_1 = 16'h0000; joystick_0 = 16'h0030; tick();
    total++; if (outs !== 10'b0000110000) begin bad++; $display("FAIL fire_start1 got=%b exp=%b", outs, 10'b0000110000); end
    joystick_0 = 16'h0040; tick();
    total++; if (outs !== 10'b0000001000) begin bad++; $display("FAIL start_swap2 got=%b exp=%b", outs, 10'b0000001000); end
    joystick_0 = 16'h0004; joystick_1 = 16'h0028; tick();
    total++; if (outs !== 10'b1100001000) begin bad++; $display("FAIL mix_players got=%b exp=%b", outs, 10'b1100001000); end
    joystick_0 = 16'h0000; joystick_1 = 16'h0000; tick();
    total++; if (outs !== 10'b0) begin bad++; $display("FAIL dir_clear got=%b exp=%b", outs, 10'b0); end
  endtask

  task automatic test_coin_hold();
    logic exp;
    joystick_0 = 16'h0080;
    for (int i = 1; i <= 200; i++) begin
      tick();
      exp = (i >= 5 && i <= 12);
      total++; if (m_coin1 !== exp) begin bad++; $display("FAIL coin_hold c%0d got=%b exp=%b", i, m_coin1, exp); end
    end
    total++; if (m_coin2 !== 1'b0) begin bad++; $display("FAIL coin_hold_p2 got=%b exp=0", m_coin2); end
    joystick_0 = 16'h0000;
    repeat (10) tick();
  endtask

  task automatic test_coin_holdoff();
    logic exp;
    joystick_0 = 16'h0080;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (i == 6)  joystick_0 = 16'h0000;
      if (i == 18) joystick_0 = 16'h0080;
      exp = (i >= 5 && i <= 12);
      total++; if (m_coin1 !== exp) begin bad++; $display("FAIL coin_holdoff c%0d got=%b exp=%b", i, m_coin1, exp); end
    end
    joystick_0 = 16'h0000;
    repeat (10) tick();
    joystick_0 = 16'h0080;
    for (int i = 1; i <= 30; i++) begin
      tick();
      exp = (i >= 5 && i <= 12);
      total++; if (m_coin1 !== exp) begin bad++; $display("FAIL coin_repress c%0d got=%b exp=%b", i, m_coin1, exp); end
    end
    joystick_0 = 16'h0000;
    repeat (10) tick();
  endtask

  task automatic test_debounce();
    logic exp;
    joystick_1 = 16'h0080;
    repeat (3) tick();
    joystick_1 = 16'h0000;
    for (int i = 1; i <= 20; i++) begin
      tick();
      total++; if (m_coin2 !== 1'b0) begin bad++; $display("FAIL glitch3 c%0d got=%b exp=0", i, m_coin2); end
    end
    joystick_1 = 16'h0080;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (i == 4) joystick_1 = 16'h0000;
      exp = (i >= 5 && i <= 12);
      total++; if (m_coin2 !== exp) begin bad++; $display("FAIL press4 c%0d got=%b exp=%b", i, m_coin2, exp); end
    end
    repeat (5) tick();
  endtask

  task automatic test_pause_dim();
    logic exp;
    joystick_0 = 16'h0100;
    for (int i = 1; i <= 110; i++) begin
      tick();
      if (i == 10) joystick_0 = 16'h0000;
      if (i == 4 || i == 5) begin
        exp = (i == 5);
        total++; if (pause !== exp) begin bad++; $display("FAIL pause_on c%0d got=%b exp=%b", i, pause, exp); end
      end
      exp = (i >= 106);
      total++; if (dim_video !== exp) begin bad++; $display("FAIL dim_on c%0d got=%b exp=%b", i, dim_video, exp); end
    end
    joystick_0 = 16'h0100;
    repeat (4) tick();
    total++; if (pause !== 1'b1) begin bad++; $display("FAIL pause_hold got=%b exp=1", pause); end
    tick();
    total++; if (pause !== 1'b0) begin bad++; $display("FAIL pause_off got=%b exp=0", pause); end
    tick();
    total++; if (dim_video !== 1'b0) begin bad++; $display("FAIL dim_off got=%b exp=0", dim_video); end
    repeat (4) tick();
    joystick_0 = 16'h0000;
    repeat (10) tick();
    osd_status = 1'b1; osd_pause_en = 1'b1; #1;
    total++; if (pause !== 1'b1) begin bad++; $display("FAIL osd_pause got=%b exp=1", pause); end
    repeat (500) tick();
    total++; if (dim_video !== 1'b0) begin bad++; $display("FAIL osd_no_dim got=%b exp=0", dim_video); end
    osd_status = 1'b0; osd_pause_en = 1'b0; hs_access = 1'b1; #1;
    total++; if (pause !== 1'b1) begin bad++; $display("FAIL hs_pause got=%b exp=1", pause); end
    repeat (150) tick();
    total++; if (dim_video !== 1'b0) begin bad++; $display("FAIL hs_no_dim got=%b exp=0", dim_video); end
    hs_access = 1'b0; #1;
    total++; if (pause !== 1'b0) begin bad++; $display("FAIL hs_release got=%b exp=0", pause); end
  endtask

  task automatic test_reset_mid();
    joystick_0 = 16'h0100;
    for (int i = 1; i <= 55; i++) begin
      tick();
      if (i == 10) joystick_0 = 16'h0000;
      if (i == 48) joystick_0 = 16'h0080;
    end
    total++; if (m_coin1 !== 1'b1) begin bad++; $display("FAIL mid_pre_coin got=%b exp=1", m_coin1); end
    total++; if (pause !== 1'b1) begin bad++; $display("FAIL mid_pre_pause got=%b exp=1", pause); end
    total++; if (dut.dim_timer !== 32'd50) begin bad++; $display("FAIL mid_pre_timer got=%0d exp=50", dut.dim_timer); end
    reset = 1'b1;
    tick();
    total++; if (m_coin1 !== 1'b0) begin bad++; $display("FAIL mid_coin got=%b exp=0", m_coin1); end
    total++; if (pause !== 1'b0) begin bad++; $display("FAIL mid_pause got=%b exp=0", pause); end
    total++; if (dut.dim_timer !== 32'd0) begin bad++; $display("FAIL mid_timer got=%0d exp=0", dut.dim_timer); end
    joystick_0 = 16'h0000;
    tick();
    reset = 1'b0;
    repeat (20) tick();
    total++; if ({pause, outs} !== 11'b0) begin bad++; $display("FAIL mid_after got=%b exp=%b", {pause, outs}, 11'b0); end
  endtask

  initial begin
    test_reset();
    test_directions();
    test_coin_hold();
    test_coin_holdoff();
    test_debounce();
    test_pause_dim();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
